soc_mst_burst_arbiter: RTL and testbench

//  Burst-granular arbiter that shares one downstream SoC-bus master slot between the crossbar masters
//  CVA6=0, DEBUG=1, IOMMU_COMP=2, IOMMU_MEM=3. Grants one requester for a whole burst of len+1 beats.

---
 rtl/soc_mst_burst_arbiter.sv | 114 +++++++++++
 tb/tb_soc_mst_burst_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_mst_burst_arbiter.sv
// Burst-granular round-robin arbiter for one shared SoC-bus master slot.
// One requester owns the slot for a whole len+1 beat burst; the debug master can optionally jump the queue.
module soc_mst_burst_arbiter #(
    parameter int   NrMasters     = 4,
    parameter int   LenWidth      = 8,
    parameter int   DbgIdx        = 1,
    parameter logic DbgPriority   = 1'b1,
    parameter int   TimeoutCycles = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NrMasters-1:0]          req_i,
    input  logic [NrMasters*LenWidth-1:0] len_i,
    input  logic                          beat_valid_i,
    input  logic                          beat_ready_i,
    output logic [NrMasters-1:0]          gnt_o,
    output logic [$clog2(NrMasters)-1:0]  gnt_idx_o,
    output logic                          busy_o,
    output logic                          last_o,
    output logic                          timeout_o
);

    localparam int IdxW = $clog2(NrMasters);
    localparam int WdW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [NrMasters-1:0] OneHot = NrMasters'(1);
    localparam logic [WdW-1:0]       WdLast = WdW'(TimeoutCycles - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state_q;
    logic [IdxW-1:0]     rr_q;
    logic [LenWidth-1:0] beat_cnt_q;
    logic [WdW-1:0]      wdog_q;

    logic            hs;
    logic [IdxW-1:0] win_idx;
    logic            win_dbg;
    logic            found;
    int              cand;

    // Beat handshake: a beat transfers only in a cycle where beat_valid_i and beat_ready_i are both high.
    assign hs        = beat_valid_i & beat_ready_i;
    assign busy_o    = (state_q == BURST);
    assign last_o    = busy_o & hs & (beat_cnt_q == '0);
    assign timeout_o = (TimeoutCycles > 0) & busy_o & ~hs & (wdog_q == WdLast);

    // Winner selection: debug override first, else first request at or after rr_q.
    always_comb begin
        win_idx = '0;
        win_dbg = 1'b0;
        found   = 1'b0;
        cand    = 0;
        if (DbgPriority && req_i[DbgIdx]) begin
            win_idx = IdxW'(DbgIdx);
            win_dbg = 1'b1;
        end else begin
            for (int i = 0; i < NrMasters; i++) begin
                cand = (int'(rr_q) + i) % NrMasters;
                if (!found && req_i[cand]) begin
                    win_idx = IdxW'(cand);
                    found   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            gnt_o      <= '0;
            gnt_idx_o  <= '0;
            rr_q       <= '0;
            beat_cnt_q <= '0;
            wdog_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        state_q    <= BURST;
                        gnt_o      <= OneHot << win_idx;
                        gnt_idx_o  <= win_idx;
                        beat_cnt_q <= len_i[int'(win_idx)*LenWidth +: LenWidth];
                        wdog_q     <= '0;
                        if (!win_dbg) begin
                            rr_q <= IdxW'((int'(win_idx) + 1) % NrMasters);
                        end
                    end
                end
                BURST: begin
                    // Final beat or watchdog expiry both release the slot; the request lines are not consulted.
                    if (last_o || timeout_o) begin
                        state_q   <= IDLE;
                        gnt_o     <= '0;
                        gnt_idx_o <= '0;
                        wdog_q    <= '0;
                    end else if (hs) begin
                        beat_cnt_q <= beat_cnt_q - 1'b1;
                        wdog_q     <= '0;
                    end else if (TimeoutCycles > 0) begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_o   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_mst_burst_arbiter.sv
// Bench for soc_mst_burst_arbiter: two configurations driven in lockstep and checked each cycle
// against a burst-level model (owner, beats remaining, stall length, next-favoured master).
module tb_soc_mst_burst_arbiter;
  localparam int N   = 4;
  localparam int LW  = 8;
  localparam int DBG = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*LW-1:0] len = '0;
  logic            bv  = 1'b0;
  logic            br  = 1'b0;

  logic [N-1:0] gnt  [2];
  logic [1:0]   gidx [2];
  logic         busy [2];
  logic         last [2];
  logic         tmo  [2];

  // clock / reset
  always #5 clk = ~clk;

  // u_a: debug override, 16-cycle watchdog. u_b: pure round-robin, watchdog disabled.
  soc_mst_burst_arbiter #(.NrMasters(N), .LenWidth(LW), .DbgIdx(DBG), .DbgPriority(1'b1),
                          .TimeoutCycles(16)) u_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .len_i(len), .beat_valid_i(bv), .beat_ready_i(br),
    .gnt_o(gnt[0]), .gnt_idx_o(gidx[0]), .busy_o(busy[0]), .last_o(last[0]), .timeout_o(tmo[0]));

  soc_mst_burst_arbiter #(.NrMasters(N), .LenWidth(LW), .DbgIdx(DBG), .DbgPriority(1'b0),
                          .TimeoutCycles(0)) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(req), .len_i(len), .beat_valid_i(bv), .beat_ready_i(br),
    .gnt_o(gnt[1]), .gnt_idx_o(gidx[1]), .busy_o(busy[1]), .last_o(last[1]), .timeout_o(tmo[1]));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: burst-level view per configuration
  bit m_busy  [2];
  int m_owner [2];
  int m_left  [2];
  int m_stall [2];
  int m_rr    [2];
  bit obs_last [2];
  bit obs_tmo  [2];
  bit obs_hs;

  function automatic bit pri_of(input int d);
    return d == 0;
  endfunction

  function automatic int tmo_of(input int d);
    return (d == 0) ? 16 : 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_owner[d] = 0; m_left[d] = 0; m_stall[d] = 0; m_rr[d] = 0;
    end
  endtask

  task automatic model_grant(input int d);
    int w;
    w = -1;
    if (pri_of(d) && req[DBG]) begin
      w = DBG;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (w < 0 && req[(m_rr[d] + j) % N]) w = (m_rr[d] + j) % N;
      end
      m_rr[d] = (w + 1) % N;
    end
    m_owner[d] = w;
    m_left[d]  = int'(len[w*LW +: LW]) + 1;
    m_stall[d] = 0;
    m_busy[d]  = 1;
  endtask

  // driver step: inputs already set; compare at negedge, advance model, return at posedge+1
  task automatic step();
    logic [N-1:0] eg;
    bit el, et;
    @(negedge clk);
    obs_hs = bv & br;
    for (int d = 0; d < 2; d++) begin
      eg = m_busy[d] ? (N'(1) << m_owner[d]) : '0;
      el = m_busy[d] && obs_hs && (m_left[d] == 1);
      et = m_busy[d] && !obs_hs && (tmo_of(d) > 0) && (m_stall[d] + 1 == tmo_of(d));
      obs_last[d] = last[d];
      obs_tmo[d]  = tmo[d];
      check($sformatf("gnt%0d", d),  32'(gnt[d]),  32'(eg));
      check($sformatf("idx%0d", d),  32'(gidx[d]), m_busy[d] ? 32'(m_owner[d]) : 32'd0);
      check($sformatf("busy%0d", d), 32'(busy[d]), 32'(m_busy[d]));
      check($sformatf("last%0d", d), 32'(last[d]), 32'(el));
      check($sformatf("tmo%0d", d),  32'(tmo[d]),  32'(et));
      if (m_busy[d]) begin
        if (obs_hs) begin
          m_left[d]--;
          m_stall[d] = 0;
          if (m_left[d] == 0) m_busy[d] = 0;
        end else begin
          m_stall[d]++;
          if (et) m_busy[d] = 0;
        end
      end else if (req != '0) begin
        model_grant(d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // async reset from any point; outputs must clear before the next edge
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_gnt%0d", d),  32'(gnt[d]),  32'd0);
      check($sformatf("rst_idx%0d", d),  32'(gidx[d]), 32'd0);
      check($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
      check($sformatf("rst_last%0d", d), 32'(last[d]), 32'd0);
      check($sformatf("rst_tmo%0d", d),  32'(tmo[d]),  32'd0);
    end
    req = '0; bv = 1'b0; br = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // scoreboard of grant order observed on one configuration
  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];

  task automatic run_log(input int n, input int d);
    bit prev;
    prev = busy[d];
    for (int i = 0; i < n; i++) begin
      step();
      if (busy[d] && !prev) got_q.push_back(gidx[d]);
      prev = busy[d];
    end
  endtask

  task automatic compare_order(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("por_gnt", 32'(gnt[0]), 32'd0);
    check("por_busy", 32'(busy[1]), 32'd0);
    do_reset();

    // single 4-beat burst, ready always high
    req = 4'b0001; len[0*LW +: LW] = 8'd3; bv = 1'b1; br = 1'b1;
    step();
    req = '0;
    for (int i = 0; i < 6; i++) step();

    // all four requesting zero-length bursts: round-robin order on the non-override arbiter
    do_reset();
    req = 4'b1111; len = '0; bv = 1'b1; br = 1'b1;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    run_log(10, 1);
    compare_order("rr_order");

    // debug override leaves the round-robin pointer untouched
    do_reset();
    req = 4'b0011; len = '0; bv = 1'b1; br = 1'b1;
    exp_q = '{2'd1, 2'd0};
    run_log(1, 0);
    req = 4'b0101;
    run_log(3, 0);
    compare_order("dbg_order");

    // watchdog: m2 stalls with ready low, then m3 is served
    do_reset();
    req = 4'b0100; len = '0; len[2*LW +: LW] = 8'd1; bv = 1'b1; br = 1'b0;
    step();
    req = 4'b1000;
    n = 0;
    while (!obs_tmo[0] && n < 40) begin
      step();
      n++;
    end
    check("tmo_cycle", 32'(n), 32'd16);
    step();
    step();
    check("after_tmo_idx", 32'(gidx[0]), 32'd3);
    req = '0; br = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // maximum length burst with ready toggling
    do_reset();
    req = 4'b0001; len = '0; len[0*LW +: LW] = 8'hFF; bv = 1'b1; br = 1'b0;
    step();
    req = '0;
    n = 0;
    for (int i = 0; i < 2000 && !obs_last[1]; i++) begin
      br = 1'($urandom_range(0, 1));
      step();
      if (obs_hs) n++;
    end
    check("max_len_beats", 32'(n), 32'd256);
    br = 1'b1;
    for (int i = 0; i < 40; i++) step();

    // reset in the middle of a 4-beat burst, then a fresh grant
    do_reset();
    req = 4'b0001; len[0*LW +: LW] = 8'd3; bv = 1'b1; br = 1'b1;
    step();
    req = '0;
    step();
    step();
    do_reset();
    req = 4'b0100;
    step();
    check("post_rst_gnt", 32'(gnt[0]), 32'h4);
    step();

    // randomized traffic with occasional long stalls
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) req = N'($urandom);
      if ($urandom_range(0, 15) == 0)
        for (int k = 0; k < N; k++) len[k*LW +: LW] = LW'($urandom_range(0, 4));
      bv = ($urandom_range(0, 9) < 7);
      br = ((i / 100) % 4 == 3) ? 1'b0 : ($urandom_range(0, 9) < 6);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
